// File: rtl/soc_addr_decode.sv
// Address decoder and single-master to multi-slave request router with in-order response tracking.
// Optional SOC_DECODE_CRYPTO_LOCK_EN adds crypto_lock_i, which maps crypto slaves (1..10) to the error index.
module soc_addr_decode #(
    parameter int unsigned MaxOutstanding = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
`ifdef SOC_DECODE_CRYPTO_LOCK_EN
    input  logic        crypto_lock_i,
`endif
    input  logic        req_i,
    output logic        gnt_o,
    input  logic [63:0] addr_i,
    input  logic        we_i,
    input  logic [63:0] wdata_i,
    input  logic [7:0]  be_i,
    output logic        rvalid_o,
    output logic [63:0] rdata_o,
    output logic        rerr_o,
    output logic        slv_req_o,
    input  logic        slv_gnt_i,
    output logic [4:0]  slv_idx_o,
    output logic [63:0] slv_addr_o,
    output logic        slv_we_o,
    output logic [63:0] slv_wdata_o,
    output logic [7:0]  slv_be_o,
    input  logic        slv_rvalid_i,
    input  logic [63:0] slv_rdata_i,
    input  logic        slv_rerr_i
);

    localparam logic [4:0] ErrIdx     = 5'd31;
    localparam int         NumRegions = 20;

    localparam logic [63:0] RegionBase [NumRegions] = '{
        64'h8000_0000, 64'h7000_0000, 64'h4100_0000, 64'h4200_0000, 64'h4300_0000,
        64'h5000_0000, 64'h6000_0000, 64'h4400_0000, 64'h4500_0000, 64'h4600_0000,
        64'h4700_0000, 64'h4000_0000, 64'h3000_0000, 64'h2000_0000, 64'h1800_0000,
        64'h1000_0000, 64'h0C00_0000, 64'h0200_0000, 64'h0001_0000, 64'h0000_0000
    };
    localparam logic [63:0] RegionLen [NumRegions] = '{
        64'h4000_0000, 64'h0001_0000, 64'h0001_0000, 64'h0000_1000, 64'h0001_0000,
        64'h0001_0000, 64'h0001_0000, 64'h0001_0000, 64'h0001_0000, 64'h0001_0000,
        64'h0001_0000, 64'h0000_1000, 64'h0001_0000, 64'h0080_0000, 64'h0000_1000,
        64'h0000_1000, 64'h03FF_FFFF, 64'h000C_0000, 64'h0001_0000, 64'h0000_1000
    };

    logic [4:0]  dec_idx;
    logic        req_valid;
    logic [4:0]  req_idx;
    logic [63:0] req_addr;
    logic        req_we;
    logic [63:0] req_wdata;
    logic [7:0]  req_be;
    logic [3:0]  cnt;
    logic [4:0]  cur_idx;
    logic        err_pend;
    logic        local_issue;
    logic        slv_issue;
    logic        issuing;
    logic        fwd_valid;
    logic        resp_fire;
    logic [4:0]  eff_cnt;
    logic [4:0]  eff_idx;
    logic        stall;
    logic        accept;

    always_comb begin
        dec_idx = ErrIdx;
        for (int i = 0; i < NumRegions; i++) begin
            if (addr_i >= RegionBase[i] && addr_i < RegionBase[i] + RegionLen[i]) begin
                dec_idx = 5'(i);
            end
        end
`ifdef SOC_DECODE_CRYPTO_LOCK_EN
        if (crypto_lock_i && dec_idx >= 5'd1 && dec_idx <= 5'd10) begin
            dec_idx = ErrIdx;
        end
`endif
    end

    assign local_issue = req_valid && (req_idx == ErrIdx);
    assign slv_issue   = req_valid && (req_idx != ErrIdx) && slv_gnt_i;
    assign issuing     = local_issue || slv_issue;

    assign fwd_valid   = slv_rvalid_i && (cnt != 4'd0) && (cur_idx != ErrIdx);
    assign resp_fire   = err_pend || fwd_valid;

    // A registered-but-unissued entry is already committed, so it counts toward the
    // outstanding limit and pins the target index; otherwise a new grant could slip past it.
    assign eff_cnt = {1'b0, cnt} + {4'd0, req_valid};
    assign eff_idx = req_valid ? req_idx : cur_idx;
    assign stall   = (eff_cnt == 5'(MaxOutstanding)) ||
                     ((eff_cnt != 5'd0) && (dec_idx != eff_idx));
    assign accept  = (!req_valid || issuing) && !stall;
    assign gnt_o   = req_i && accept && rst_ni;

    assign slv_req_o   = req_valid && (req_idx != ErrIdx);
    assign slv_idx_o   = req_idx;
    assign slv_addr_o  = req_addr;
    assign slv_we_o    = req_we;
    assign slv_wdata_o = req_wdata;
    assign slv_be_o    = req_be;

    assign rvalid_o = resp_fire;
    assign rerr_o   = err_pend || (fwd_valid && slv_rerr_i);
    assign rdata_o  = fwd_valid ? slv_rdata_i : 64'd0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            req_valid <= 1'b0;
            req_idx   <= 5'd0;
            req_addr  <= 64'd0;
            req_we    <= 1'b0;
            req_wdata <= 64'd0;
            req_be    <= 8'd0;
        end else if (gnt_o) begin
            req_valid <= 1'b1;
            req_idx   <= dec_idx;
            req_addr  <= addr_i;
            req_we    <= we_i;
            req_wdata <= wdata_i;
            req_be    <= be_i;
        end else if (issuing) begin
            req_valid <= 1'b0;
        end
    end

    // Issue and response in the same cycle leave the count unchanged.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt      <= 4'd0;
            cur_idx  <= 5'd0;
            err_pend <= 1'b0;
        end else begin
            err_pend <= local_issue;
            if (issuing) begin
                cur_idx <= req_idx;
            end
            if (issuing && !resp_fire) begin
                cnt <= cnt + 4'd1;
            end else if (!issuing && resp_fire) begin
                cnt <= cnt - 4'd1;
            end
        end
    end

endmodule

// File: doc/soc_addr_decode.md
SOC_ADDR_DECODE -- requirements
Module: soc_addr_decode

Interface
REQ-001 SHALL have parameter MaxOutstanding, default 4, meaning the maximum number of granted requests without a response (range 1..15).
REQ-002 SHALL have ports clk_i  in  1  clock; rst_ni  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have upstream request ports req_i in 1; gnt_o out 1; addr_i in 64; we_i in 1; wdata_i in 64; be_i in 8.
REQ-004 SHALL have upstream response ports rvalid_o out 1; rdata_o out 64; rerr_o out 1 (decode or slave error).
REQ-005 SHALL have downstream request ports slv_req_o out 1; slv_gnt_i in 1; slv_idx_o out 5; slv_addr_o out 64; slv_we_o out 1; slv_wdata_o out 64; slv_be_o out 8.
REQ-006 SHALL have downstream response ports slv_rvalid_i in 1; slv_rdata_i in 64; slv_rerr_i in 1.

Function
REQ-007 SHALL decode addr_i to a slave index as follows (base, length; hit when base <= addr < base+length): 0 DRAM 0x8000_0000,0x4000_0000; 1 ECIES 0x7000_0000,0x1_0000; 2 PUF 0x4100_0000,0x1_0000; 3 ODO 0x4200_0000,0x1000; 4 SHA 0x4300_0000,0x1_0000; 5 RSA 0x5000_0000,0x1_0000; 6 TRNG 0x6000_0000,0x1_0000; 7 ECC 0x4400_0000,0x1_0000; 8 AES 0x4500_0000,0x1_0000; 9 DH 0x4600_0000,0x1_0000; 10 ECDSA 0x4700_0000,0x1_0000; 11 GPIO 0x4000_0000,0x1000; 12 Ethernet 0x3000_0000,0x1_0000; 13 SPI 0x2000_0000,0x80_0000; 14 Timer 0x1800_0000,0x1000; 15 UART 0x1000_0000,0x1000; 16 PLIC 0x0C00_0000,0x3FF_FFFF; 17 CLINT 0x0200_0000,0xC_0000; 18 ROM 0x1_0000,0x1_0000; 19 Debug 0x0,0x1000.
REQ-008 SHALL treat an address matching no region as ErrIdx = 31.
REQ-009 SHALL hold a one-entry request register (valid, idx, addr, we, wdata, be); gnt_o = req_i && accept, where accept = (register empty || register issuing this cycle) && stall-free.
REQ-010 SHALL capture a granted request into the register on the same edge; slv_req_o asserts the cycle after grant (latency 1) when idx != 31.
REQ-011 SHALL hold slv_* request outputs stable while slv_req_o && !slv_gnt_i; register empties on slv_gnt_i.
REQ-012 SHALL keep an outstanding counter (0..MaxOutstanding) and a current-index register; counter +1 on issue (slave grant or local-error issue), -1 on response, unchanged when both occur together.
REQ-013 SHALL stall (gnt_o=0) when counter == MaxOutstanding, or counter != 0 and decoded idx != current index; this guarantees in-order responses.
REQ-014 SHALL issue an idx-31 entry locally (no slv_req_o) in the cycle it is registered, and return rvalid_o=1, rerr_o=1, rdata_o=0 exactly one cycle later.
REQ-015 SHALL forward slv_rvalid_i/slv_rdata_i/slv_rerr_i to rvalid_o/rdata_o/rerr_o combinationally when the current index != 31.
REQ-016 SHALL ignore slv_rvalid_i while counter == 0 (counter does not underflow).
REQ-017 SHALL not stall on a write versus read mix; we_i has no effect on ordering.

Reset
REQ-018 SHALL on rst_ni low asynchronously clear request register valid, counter to 0, current index to 0, and the local-error pending flag.
REQ-019 SHALL drive gnt_o=0, slv_req_o=0, rvalid_o=0, rerr_o=0, rdata_o=0, slv_idx_o=0 while in reset; in-flight transactions are dropped.

Configuration
REQ-020 SHALL, when SOC_DECODE_CRYPTO_LOCK_EN is defined, add input crypto_lock_i (1 bit); while it is high, addresses decoding to indices 1..10 SHALL be remapped to ErrIdx 31.
REQ-021 SHALL, without SOC_DECODE_CRYPTO_LOCK_EN, have no crypto_lock_i port and decode indices 1..10 normally.

Verification
REQ-022 Read 0x4500_0010 with slv_gnt_i=1 -> slv_req_o the next cycle with slv_idx_o=8; rdata 0xDEAD returned with rerr_o=0.
REQ-023 Access to 0x9000_0000_0000 -> no slv_req_o; rvalid_o=1, rerr_o=1, rdata_o=0 two cycles after grant.
REQ-024 Four DRAM reads with slv_rvalid_i held low -> the fifth request sees gnt_o=0 until the first response arrives.
REQ-025 UART read outstanding, then a request to SHA 0x4300_0000 -> gnt_o=0 until the UART response arrives, then granted.
REQ-026 With SOC_DECODE_CRYPTO_LOCK_EN defined and crypto_lock_i=1, a write to 0x5000_0000 -> local error and no slv_req_o; with crypto_lock_i=0 the write goes to idx 5.
REQ-027 Assert rst_ni low while two requests are outstanding -> counter reads 0 and all outputs are 0; the first request after reset is granted immediately.
